// File: rtl/rr_arb4_sel.sv
// Four-channel round-robin arbiter that drives the mux4 select bus with a registered one-hot grant.
// Optional tenure limit: define RR_ARB_TIMEOUT_EN to force-release grants held for HOLD_MAX cycles.
module rr_arb4_sel #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     r_state, w_state_next;
    logic [3:0] r_gnt, w_gnt_next;
    logic [1:0] r_sel, w_sel_next;
    logic [1:0] r_last, w_last_next;

    logic [1:0] w_cand [4];
    logic [3:0] w_hit;
    logic [1:0] w_pick;
    logic       w_release;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
        $error("rr_arb4_sel: HOLD_MAX must be in 1..255");
    end

    // Candidate gi is the channel visited at search position gi, starting just after last.
    for (genvar gi = 0; gi < 4; gi++) begin : g_search
        assign w_cand[gi] = r_last + 2'(gi + 1);
        assign w_hit[gi]  = req[w_cand[gi]];
    end

    always_comb begin
        w_pick = r_last;
        for (int i = 3; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_pick = w_cand[i];
            end
        end
    end

    assign w_release = ack | ~req[r_sel];

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] r_cnt, w_cnt_next;
    logic       r_timeout, w_timeout_next;
    logic       w_limit;

    // The HOLD_MAX-th cycle of tenure is the one whose closing edge releases.
    assign w_limit = (r_cnt == 8'(HOLD_MAX - 1));
`endif

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_sel_next   = r_sel;
        w_last_next  = r_last;
`ifdef RR_ARB_TIMEOUT_EN
        w_cnt_next     = r_cnt;
        w_timeout_next = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (req != 4'b0000) begin
                    w_state_next = GRANT;
                    w_gnt_next   = 4'b0001 << w_pick;
                    w_sel_next   = w_pick;
                    w_last_next  = w_pick;
`ifdef RR_ARB_TIMEOUT_EN
                    w_cnt_next   = 8'd0;
`endif
                end
            end
            GRANT: begin
`ifdef RR_ARB_TIMEOUT_EN
                w_cnt_next = r_cnt + 8'd1;
                if (w_release || w_limit) begin
                    w_state_next   = IDLE;
                    w_gnt_next     = 4'b0000;
                    w_timeout_next = ~w_release;
                end
`else
                if (w_release) begin
                    w_state_next = IDLE;
                    w_gnt_next   = 4'b0000;
                end
`endif
            end
            default: begin
                w_state_next = IDLE;
                w_gnt_next   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_sel   <= w_sel_next;
            r_last  <= w_last_next;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = (r_state == GRANT);

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Directed bench for rr_arb4_sel: reset, rotation, sparse requests, request drop, tenure limit, async reset.
module tb_rr_arb4_sel;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    rr_arb4_sel #(.HOLD_MAX(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ack     (ack),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic b, input logic t);
        check({tag, ".gnt"}, {4'b0, gnt}, {4'b0, g});
        check({tag, ".sel"}, {6'b0, sel}, {6'b0, s});
        check({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
        check({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
    endtask

    logic [1:0] rot_exp [5]    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] sparse_exp [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        ack   = 1'b0;

        // Reset held with all requests pending
        step();
        step();
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Rotation with all channels requesting
        for (int i = 0; i < 5; i++) begin
            check_out($sformatf("rot%0d_grant", i), 4'b0001 << rot_exp[i], rot_exp[i], 1'b1, 1'b0);
            ack = 1'b1;
            step();
            check_out($sformatf("rot%0d_idle", i), 4'b0000, rot_exp[i], 1'b0, 1'b0);
            ack = 1'b0;
            if (i < 4) step();
        end

        // Sparse requests alternate ch1 and ch3
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("sparse%0d_grant", i), 4'b0001 << sparse_exp[i], sparse_exp[i], 1'b1, 1'b0);
            ack = 1'b1;
            step();
            check_out($sformatf("sparse%0d_idle", i), 4'b0000, sparse_exp[i], 1'b0, 1'b0);
            ack = 1'b0;
        end

        // Request drop on ch2; other requests arriving mid-grant are ignored
        req = 4'b0100;
        step();
        check_out("drop_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0111;
        step();
        check_out("drop_others_ignored", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0011;
        step();
        check_out("drop_release", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Tenure behaviour with a lone requester on ch0
        req = 4'b0001;
        step();
        check_out("hold_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 2; i <= 4; i++) begin
            step();
            check_out($sformatf("hold_c%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step();
        check_out("timeout_release", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        check_out("timeout_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            step();
            check_out($sformatf("hold2_c%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        ack = 1'b1;
        step();
        check_out("ack_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
        ack = 1'b0;
`else
        for (int i = 2; i <= 10; i++) begin
            step();
            check_out($sformatf("hold_c%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        ack = 1'b1;
        step();
        check_out("hold_ack_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        ack = 1'b0;
`endif

        // Asynchronous reset in the middle of a ch3 grant
        req = 4'b1000;
        step();
        check_out("ch3_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1001;
        step();
        check_out("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("post_reset_ch0", 4'b0001, 2'd0, 1'b1, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        check_out("post_reset_ch3", 4'b1000, 2'd3, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
